param_reg_file: RTL

- Next-generation architectural register file for the pipelined ARM core.
- Generalised to NUM_READ read ports and two write ports: writeback, plus a second port for load-multiple and SP update.
- Synchronous registered read with one-cycle latency, full write-to-read bypass, and a pipeline stall hold.
- PC is owned by the fetch stage. SP and PC are exported as dedicated taps.
- Sits between decode (read addresses) and execute (read data); writes come from writeback.

---
 rtl/reg_file_pkg.sv | 22 ++
 rtl/param_reg_file_if.sv | 48 ++++
 rtl/reg_file_bypass_sel.sv | 29 ++
 rtl/param_reg_file.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and index defaults for the architectural register file.
package reg_file_pkg;

    localparam int REG_DATA_W   = 32;
    localparam int NUM_REGS_DEF = 16;
    localparam int NUM_READ_DEF = 3;
    localparam int REG_ADDR_W   = $clog2(NUM_REGS_DEF);

    localparam int SP_IDX_DEF = 13;
    localparam int LR_IDX_DEF = 14;
    localparam int PC_IDX_DEF = 15;

    typedef logic [REG_DATA_W-1:0] word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic      en;
        reg_addr_t addr;
        word_t     data;
    } wr_port_t;

endpackage

// File: rtl/param_reg_file_if.sv
// Decode/writeback/fetch side bundle of the register file.
// Parity test and error signals exist only when REGFILE_PARITY_EN is defined.
interface param_reg_file_if #(
    parameter int DATA_W   = reg_file_pkg::REG_DATA_W,
    parameter int NUM_REGS = reg_file_pkg::NUM_REGS_DEF,
    parameter int NUM_READ = reg_file_pkg::NUM_READ_DEF
);
    localparam int AW = $clog2(NUM_REGS);

    logic                               stall_i;
    logic [NUM_READ-1:0][AW-1:0]        rd_addr_i;
    logic [NUM_READ-1:0][DATA_W-1:0]    rd_data_o;
    logic                               wr0_en_i;
    logic [AW-1:0]                      wr0_addr_i;
    logic [DATA_W-1:0]                  wr0_data_i;
    logic                               wr1_en_i;
    logic [AW-1:0]                      wr1_addr_i;
    logic [DATA_W-1:0]                  wr1_data_i;
    logic [DATA_W-1:0]                  pc_i;
    logic [DATA_W-1:0]                  pc_o;
    logic [DATA_W-1:0]                  sp_o;
    logic                               wr_conflict_o;
`ifdef REGFILE_PARITY_EN
    logic                               inj_par_i;
    logic                               parity_err_o;
`endif

    modport master (
        output stall_i, rd_addr_i, wr0_en_i, wr0_addr_i, wr0_data_i,
               wr1_en_i, wr1_addr_i, wr1_data_i, pc_i,
        input  rd_data_o, pc_o, sp_o, wr_conflict_o
`ifdef REGFILE_PARITY_EN
        , output inj_par_i
        , input  parity_err_o
`endif
    );

    modport slave (
        input  stall_i, rd_addr_i, wr0_en_i, wr0_addr_i, wr0_data_i,
               wr1_en_i, wr1_addr_i, wr1_data_i, pc_i,
        output rd_data_o, pc_o, sp_o, wr_conflict_o
`ifdef REGFILE_PARITY_EN
        , input  inj_par_i
        , output parity_err_o
`endif
    );

endinterface

// File: rtl/reg_file_bypass_sel.sv
// Per-read-port priority mux: captured wr1, then captured wr0, then captured array data.
module reg_file_bypass_sel
    import reg_file_pkg::*;
#(
    parameter int  DATA_W = REG_DATA_W,
    parameter int  ADDR_W = REG_ADDR_W,
    parameter type port_t = wr_port_t
) (
    input  logic [DATA_W-1:0] arr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  port_t             wr0_i,
    input  port_t             wr1_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              bypass_o
);

    always_comb begin
        rd_data_o = arr_data_i;
        bypass_o  = 1'b0;
        if (wr1_i.en && (wr1_i.addr == rd_addr_i)) begin
            rd_data_o = wr1_i.data;
            bypass_o  = 1'b1;
        end else if (wr0_i.en && (wr0_i.addr == rd_addr_i)) begin
            rd_data_o = wr0_i.data;
            bypass_o  = 1'b1;
        end
    end

endmodule

// File: rtl/param_reg_file.sv
// Architectural register file: registered reads with write bypass, stall hold, PC/SP taps.
// Optional even-parity storage and checking under REGFILE_PARITY_EN.
module param_reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_READ = NUM_READ_DEF,
    parameter int SP_IDX   = SP_IDX_DEF,
    parameter int PC_IDX   = PC_IDX_DEF
) (
    input logic             clk_i,
    input logic             rst_n_i,
    param_reg_file_if.slave bus
);

    localparam int AW = $clog2(NUM_REGS);

    typedef struct packed {
        logic              en;
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
    } port_t;

    logic [DATA_W-1:0]               regs [NUM_REGS];
    port_t                           wr0_eff, wr1_eff, wr0_q, wr1_q;
    logic [NUM_READ-1:0][DATA_W-1:0] arr_q;
    logic [NUM_READ-1:0][AW-1:0]     addr_q;
    logic [NUM_READ-1:0][DATA_W-1:0] rd_data;
    logic                            conflict_q;

    // PC writes are dropped here, so a captured port can never bypass the PC entry.
    always_comb begin
        wr0_eff.en   = bus.wr0_en_i && (bus.wr0_addr_i != AW'(PC_IDX));
        wr0_eff.addr = bus.wr0_addr_i;
        wr0_eff.data = bus.wr0_data_i;
        wr1_eff.en   = bus.wr1_en_i && (bus.wr1_addr_i != AW'(PC_IDX));
        wr1_eff.addr = bus.wr1_addr_i;
        wr1_eff.data = bus.wr1_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == PC_IDX)
                    regs[i] <= bus.pc_i;
                else if (wr1_eff.en && (wr1_eff.addr == AW'(i)))
                    regs[i] <= wr1_eff.data;
                else if (wr0_eff.en && (wr0_eff.addr == AW'(i)))
                    regs[i] <= wr0_eff.data;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            arr_q  <= '0;
            addr_q <= '0;
            wr0_q  <= '0;
            wr1_q  <= '0;
        end else if (!bus.stall_i) begin
            wr0_q <= wr0_eff;
            wr1_q <= wr1_eff;
            for (int p = 0; p < NUM_READ; p++) begin
                addr_q[p] <= bus.rd_addr_i[p];
                arr_q[p]  <= regs[bus.rd_addr_i[p]];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) conflict_q <= 1'b0;
        else          conflict_q <= wr0_eff.en && wr1_eff.en && (wr0_eff.addr == wr1_eff.addr);
    end

`ifdef REGFILE_PARITY_EN
    logic [NUM_READ-1:0] bypass;
`endif

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        reg_file_bypass_sel #(
            .DATA_W (DATA_W),
            .ADDR_W (AW),
            .port_t (port_t)
        ) u_sel (
            .arr_data_i (arr_q[p]),
            .rd_addr_i  (addr_q[p]),
            .wr0_i      (wr0_q),
            .wr1_i      (wr1_q),
            .rd_data_o  (rd_data[p]),
`ifdef REGFILE_PARITY_EN
            .bypass_o   (bypass[p])
`else
            .bypass_o   ()
`endif
        );
    end

    assign bus.rd_data_o     = rd_data;
    assign bus.pc_o          = regs[PC_IDX];
    assign bus.sp_o          = regs[SP_IDX];
    assign bus.wr_conflict_o = conflict_q;

`ifdef REGFILE_PARITY_EN
    logic                par [NUM_REGS];
    logic [NUM_READ-1:0] par_q;
    logic                par_err_d, par_err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_REGS; i++) par[i] <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == PC_IDX)
                    par[i] <= ^bus.pc_i;
                else if (wr1_eff.en && (wr1_eff.addr == AW'(i)))
                    par[i] <= ^wr1_eff.data;
                else if (wr0_eff.en && (wr0_eff.addr == AW'(i)))
                    par[i] <= (^wr0_eff.data) ^ bus.inj_par_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            par_q <= '0;
        end else if (!bus.stall_i) begin
            for (int p = 0; p < NUM_READ; p++) par_q[p] <= par[bus.rd_addr_i[p]];
        end
    end

    always_comb begin
        par_err_d = 1'b0;
        for (int p = 0; p < NUM_READ; p++) begin
            if (!bypass[p] && (par_q[p] != ^arr_q[p])) par_err_d = 1'b1;
        end
    end

    // Evaluated on the next non-stalled edge so each captured read flags at most once.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) par_err_q <= 1'b0;
        else          par_err_q <= par_err_d && !bus.stall_i;
    end

    assign bus.parity_err_o = par_err_q;
`endif

endmodule
